// File: rtl/wb_mem_bist.sv
// Wishbone memory BIST master: writes a generated pattern over [base, base+len), reads it back
// and counts mismatches. Define WB_MEM_BIST_LFSR_EN for LFSR data, otherwise address ^ 16'h5A5A.
module wb_mem_bist #(
  parameter int unsigned WB_ADDR_WIDTH  = 24,
  parameter int unsigned WB_DATA_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start_i,
  input  logic [WB_ADDR_WIDTH-1:0] base_adr_i,
  input  logic [WB_ADDR_WIDTH-1:0] len_i,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic [1:0]               wb_sel_o,
  input  logic                     wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [15:0]              err_cnt_o,
  output logic [WB_ADDR_WIDTH-1:0] first_err_adr_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrGap, StRdReq, StRdGap, StDone} state_e;

  state_e                   state_q;
  logic [WB_ADDR_WIDTH-1:0] base_q, len_q, idx_q;
  logic [CntW-1:0]          wait_cnt_q;
  logic [WB_ADDR_WIDTH-1:0] next_adr;
  logic [WB_DATA_WIDTH-1:0] exp_data, gap_data, start_data;

  assign next_adr = base_q + idx_q;
  assign wb_sel_o = wb_cyc_o ? 2'b11 : 2'b00;

`ifdef WB_MEM_BIST_LFSR_EN
  localparam logic [WB_DATA_WIDTH-1:0] LfsrSeed = 16'hACE1;
  logic [WB_DATA_WIDTH-1:0] lfsr_q;
  logic                     lfsr_reload, lfsr_step;

  // Reload on every run start and again before the read pass so reads replay the write sequence.
  always_comb begin
    lfsr_reload = (((state_q == StIdle) || (state_q == StDone)) && start_i) ||
                  ((state_q == StWrGap) && (idx_q == len_q));
    lfsr_step   = ((state_q == StWrReq) || (state_q == StRdReq)) && wb_ack_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || lfsr_reload) begin
      lfsr_q <= LfsrSeed;
    end else if (lfsr_step) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign exp_data   = lfsr_q;
  assign gap_data   = lfsr_q;
  assign start_data = LfsrSeed;
`else
  localparam logic [WB_DATA_WIDTH-1:0] Pattern = 16'h5A5A;

  assign exp_data   = wb_adr_o[WB_DATA_WIDTH-1:0] ^ Pattern;
  assign gap_data   = next_adr[WB_DATA_WIDTH-1:0] ^ Pattern;
  assign start_data = base_adr_i[WB_DATA_WIDTH-1:0] ^ Pattern;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q         <= StIdle;
      base_q          <= '0;
      len_q           <= '0;
      idx_q           <= '0;
      wait_cnt_q      <= '0;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      wb_we_o         <= 1'b0;
      wb_adr_o        <= '0;
      wb_dat_o        <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      timeout_o       <= 1'b0;
      err_cnt_o       <= '0;
      first_err_adr_o <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            base_q          <= base_adr_i;
            len_q           <= len_i;
            idx_q           <= '0;
            wait_cnt_q      <= '0;
            timeout_o       <= 1'b0;
            err_cnt_o       <= '0;
            first_err_adr_o <= '0;
            if (len_i == '0) begin
              state_q <= StDone;
              done_o  <= 1'b1;
              pass_o  <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              state_q  <= StWrReq;
              done_o   <= 1'b0;
              pass_o   <= 1'b0;
              busy_o   <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_adr_o <= base_adr_i;
              wb_dat_o <= start_data;
            end
          end
        end
        StWrReq, StRdReq: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            idx_q    <= idx_q + 1'b1;
            state_q  <= (state_q == StWrReq) ? StWrGap : StRdGap;
            if ((state_q == StRdReq) && (wb_dat_i != exp_data)) begin
              if (err_cnt_o == '0) first_err_adr_o <= wb_adr_o;
              if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
            end
          end else if (wait_cnt_q == CntLast) begin
            state_q   <= StDone;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StWrGap: begin
          wait_cnt_q <= '0;
          wb_cyc_o   <= 1'b1;
          wb_stb_o   <= 1'b1;
          if (idx_q == len_q) begin
            state_q  <= StRdReq;
            idx_q    <= '0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= base_q;
            wb_dat_o <= '0;
          end else begin
            state_q  <= StWrReq;
            wb_adr_o <= next_adr;
            wb_dat_o <= gap_data;
          end
        end
        StRdGap: begin
          if (idx_q == len_q) begin
            state_q <= StDone;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            pass_o  <= (err_cnt_o == '0);
          end else begin
            state_q    <= StRdReq;
            wait_cnt_q <= '0;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            wb_adr_o   <= next_adr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
